if_stage: RTL

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register (IF_ID_pc, IF_ID_inst, IF_ID_vld) consumed by the decode stage.
- Honours hazard stalls via a one-entry skid buffer, and branch redirects from EX, including drop of an in-flight fetch.

---
 rtl/if_stage_pkg.sv | 18 +
 rtl/if_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and fetch constants.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_HOLD,
    IF_DROP
  } if_state_e;

  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] IF_PC_INC   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a time,
// and feeds the IF/ID register with a one-entry skid for stalls and redirect handling.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_vld
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic        req_q, req_d;
  logic        wr;
  logic [31:0] tgt;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_inst_d = ifid_inst_q;
    ifid_vld_d  = ifid_vld_q;
    wr          = 1'b0;
    tgt         = align_pc(br_target);

    case (state_q)
      IF_IDLE: begin
        if (br_taken) pc_d = tgt;
        req_addr_d = br_taken ? tgt : pc_q;
        state_d    = IF_REQ;
      end
      IF_REQ: begin
        if (br_taken) begin
          pc_d = tgt;
          // an unacked request cannot be withdrawn; let it finish in DROP
          if (imem_ack) req_addr_d = tgt;
          else          state_d    = IF_DROP;
        end else if (imem_ack) begin
          pc_d = req_addr_q + IF_PC_INC;
          if (stall) begin
            buf_pc_d   = req_addr_q;
            buf_inst_d = imem_rdata;
            state_d    = IF_HOLD;
          end else begin
            ifid_pc_d   = req_addr_q;
            ifid_inst_d = imem_rdata;
            ifid_vld_d  = 1'b1;
            wr          = 1'b1;
            req_addr_d  = req_addr_q + IF_PC_INC;
          end
        end
      end
      IF_HOLD: begin
        if (br_taken) begin
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = IF_REQ;
        end else if (!stall) begin
          ifid_pc_d   = buf_pc_q;
          ifid_inst_d = buf_inst_q;
          ifid_vld_d  = 1'b1;
          wr          = 1'b1;
          req_addr_d  = pc_q;
          state_d     = IF_REQ;
        end
      end
      IF_DROP: begin
        if (br_taken) pc_d = tgt;
        if (imem_ack) begin
          req_addr_d = br_taken ? tgt : pc_q;
          state_d    = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase

    if (br_taken) begin
      ifid_vld_d  = 1'b0;
      ifid_inst_d = NOP_INST;
      buf_pc_d    = '0;
      buf_inst_d  = NOP_INST;
    end else if (!wr && !stall) begin
      ifid_vld_d  = 1'b0;
      ifid_inst_d = NOP_INST;
    end

    req_d = (state_d == IF_REQ) || (state_d == IF_DROP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_pc_q    <= '0;
      buf_inst_q  <= NOP_INST;
      ifid_pc_q   <= '0;
      ifid_inst_q <= NOP_INST;
      ifid_vld_q  <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_vld_q  <= ifid_vld_d;
      req_q       <= req_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = req_addr_q;
  assign IF_ID_pc   = ifid_pc_q;
  assign IF_ID_inst = ifid_inst_q;
  assign IF_ID_vld  = ifid_vld_q;

endmodule
